mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  CPU-side initiator for the single-ported unified Memory (instructions at bytes 512+, data at bytes 0..63).
//  Arbitrates each cycle between the IF-stage fetch and the MEM-stage load/store, and drives MemRead/MemWrite/fun3/addr/data_in.
//  Captures Memory.data_out into registered responses and raises a fetch stall for the hazard unit.
//  Checks alignment and range on data accesses before they reach Memory.
// PARAMETERS
//  STARVE_MAX  4  consecutive data grants with fetch waiting before one fetch cycle is forced (1..15)
//  DATA_BYTES  64  data window size in bytes; dm_addr >= DATA_BYTES is out of range
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request
//  if_pc      in   32  byte PC; word index if_pc[7:2] is driven on addr
//  if_ready   out  1   fetch granted this cycle
//  if_stall   out  1   if_req & ~if_ready (combinational)
//  if_valid   out  1   registered: if_instr valid
//  if_instr   out  32  registered fetched instruction
//  dm_req     in   1   data request
//  dm_we      in   1   1 = store, 0 = load
//  dm_fun3    in   3   RV32 load/store funct3
//  dm_addr    in   32  byte address
//  dm_wdata   in   32  store data
//  dm_ready   out  1   data request accepted this cycle
//  dm_valid   out  1   registered: data response (load data or store ack)
//  dm_rdata   out  32  registered load data; 0 for stores and errors
//  dm_err     out  1   registered: misaligned, out-of-range or illegal fun3
//  MemRead    out  1   to Memory
//  MemWrite   out  1   to Memory
//  fun3       out  3   to Memory
//  addr       out  6   to Memory: word index for fetch, byte address for data
//  data_in    out  32  to Memory
//  data_out   in   32  from Memory (combinational read)
// BEHAVIOUR
//  Reset: all registered outputs 0, state S_IF, starvation counter 0; async assert, sync release.
//  Handshake: a request is accepted when req & ready in the same cycle; the requester holds its inputs until then.
//  Legal data access: fun3 in {000,001,010,100,101} for loads and {000,001,010} for stores.
//    Halfwords must be 2-aligned, words 4-aligned, and dm_addr+size <= DATA_BYTES.
//  FSM states (registered grant of the previous cycle):
//    S_IF: last cycle fetched or idle.
//    S_DM: last cycle served data.
//    S_FORCE: STARVE_MAX data grants in a row with if_req high; this cycle the fetch wins and dm_ready=0.
//  Grant rule (S_IF/S_DM): data wins when dm_req is high; otherwise the fetch is granted when if_req is high.
//  Counter: increments on each data grant while if_req is high; clears on any fetch grant or when if_req is low.
//    Reaching STARVE_MAX enters S_FORCE, which returns to S_IF after exactly one cycle.
//  Legal data grant: MemRead=~dm_we, MemWrite=dm_we, fun3=dm_fun3, addr=dm_addr[5:0], data_in=dm_wdata.
//    The store commits in Memory at this edge.
//  Illegal data grant: dm_ready=1, MemRead=MemWrite=0, so the port falls to the fetch path.
//    if_ready=if_req in the same cycle. Next cycle: dm_valid=1, dm_err=1, dm_rdata=0.
//  Fetch grant: MemRead=MemWrite=0, addr=if_pc[7:2], fun3=0, data_in=0.
//  Latency: one cycle for both paths.
//    if_valid/if_instr and dm_valid/dm_rdata are registered from data_out at the granting edge.
//    The valid bits are 1-cycle pulses.
//  When if_ready=0, if_instr holds its last value and if_valid=0.
//  Simultaneous if_req & dm_req: data first; the fetch stalls one cycle unless the access is illegal.
//  Reset mid-access: an in-flight response is dropped; a store granted in that cycle may or may not have committed.
// TESTING
//  1. Reset, then if_req=1 with PCs 0,4,8 -> one cycle later each, if_valid=1, if_instr = mem[515:512], [519:516], [523:520].
//  2. Load: dm_req=1, dm_we=0, fun3=000, addr=0 with mem[0]=8'hF5 -> next cycle dm_rdata=32'hFFFFFFF5, dm_err=0.
//     Same access with fun3=100 -> 32'h000000F5.
//  3. Store then load: SW 32'hDEADBEEF to addr 8, then LW addr 8 -> dm_rdata=32'hDEADBEEF.
//     if_stall=1 during both grants while if_req=1.
//  4. Starvation: dm_req and if_req held high, STARVE_MAX=4 -> 4 data grants, 1 forced fetch (dm_ready=0), pattern repeats.
//  5. Errors: LW addr 6, LH addr 3, SW addr 62 -> dm_err=1, dm_rdata=0, MemWrite never 1, and the fetch is granted in the same cycle.
//  6. rst low during a load grant -> all outputs 0 asynchronously; after release, the first fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port Memory initiator: arbitrates instruction fetch against data load/store,
// screens data accesses for alignment, range and funct3, and registers both responses.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned DATA_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    output logic        if_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_fun3,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  fun3,
    output logic [5:0]  addr,
    output logic [31:0] data_in,
    input  logic [31:0] data_out
);

    typedef enum logic [1:0] {S_IF, S_DM, S_FORCE} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        dm_valid_q, dm_valid_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_err_q, dm_err_d;

    logic [2:0]  accSize;
    logic        fun3Ok;
    logic        alignOk;
    logic        rangeOk;
    logic        legal;
    logic        dmGrant;
    logic        legalGrant;
    logic        fetchGrant;

    // The 33-bit sum keeps addresses near 2^32 from wrapping back into the window.
    always_comb begin
        accSize = 3'd4;
        case (dm_fun3[1:0])
            2'b00:   accSize = 3'd1;
            2'b01:   accSize = 3'd2;
            default: accSize = 3'd4;
        endcase

        fun3Ok = 1'b0;
        if (dm_we) begin
            fun3Ok = dm_fun3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            fun3Ok = dm_fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end

        alignOk = 1'b1;
        if (dm_fun3[1:0] == 2'b01) begin
            alignOk = ~dm_addr[0];
        end else if (dm_fun3[1:0] == 2'b10) begin
            alignOk = (dm_addr[1:0] == 2'b00);
        end

        rangeOk = ({1'b0, dm_addr} + {30'd0, accSize}) <= 33'(DATA_BYTES);
        legal   = fun3Ok & alignOk & rangeOk;
    end

    // A rejected data access still gets dm_ready, and the port is handed to the fetch.
    always_comb begin
        dmGrant    = dm_req & (state_q != S_FORCE);
        legalGrant = dmGrant & legal;
        fetchGrant = if_req & ~legalGrant;
    end

    assign dm_ready = dmGrant;
    assign if_ready = fetchGrant;
    assign if_stall = if_req & ~fetchGrant;
    assign MemRead  = legalGrant & ~dm_we;
    assign MemWrite = legalGrant & dm_we;
    assign fun3     = legalGrant ? dm_fun3 : 3'b000;
    assign addr     = legalGrant ? dm_addr[5:0] : if_pc[7:2];
    assign data_in  = legalGrant ? dm_wdata : 32'd0;

    always_comb begin
        state_d    = S_IF;
        cnt_d      = cnt_q;
        if_valid_d = fetchGrant;
        if_instr_d = if_instr_q;
        dm_valid_d = dmGrant;
        dm_err_d   = dmGrant & ~legal;
        dm_rdata_d = dm_rdata_q;

        if (fetchGrant || !if_req) begin
            cnt_d = 4'd0;
        end else if (dmGrant) begin
            cnt_d = cnt_q + 4'd1;
        end

        if (cnt_d == 4'(STARVE_MAX)) begin
            state_d = S_FORCE;
        end else if (dmGrant) begin
            state_d = S_DM;
        end

        if (fetchGrant) begin
            if_instr_d = data_out;
        end
        if (dmGrant) begin
            dm_rdata_d = (legal && !dm_we) ? data_out : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IF;
            cnt_q      <= 4'd0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            dm_valid_q <= 1'b0;
            dm_rdata_q <= 32'd0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            dm_valid_q <= dm_valid_d;
            dm_rdata_q <= dm_rdata_d;
            dm_err_q   <= dm_err_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign dm_valid = dm_valid_q;
    assign dm_rdata = dm_rdata_q;
    assign dm_err   = dm_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array Memory model, directed stimulus, and a
// queue scoreboard drained by a monitor whenever a registered response is valid.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        if_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_fun3;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  fun3;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    logic [7:0]  mem [0:767];
    logic [9:0]  dIdx;
    logic [9:0]  iIdx;

    logic [31:0] ifQ[$];
    logic [32:0] dmQ[$];
    logic [31:0] fetchExp;
    int          checks;
    int          passes;

    mem_port_arbiter #(.STARVE_MAX(4), .DATA_BYTES(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_pc    (if_pc),
        .if_ready (if_ready),
        .if_stall (if_stall),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_fun3  (dm_fun3),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ready (dm_ready),
        .dm_valid (dm_valid),
        .dm_rdata (dm_rdata),
        .dm_err   (dm_err),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .fun3     (fun3),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data window at byte 0, instruction words at byte 512 + 4*addr.
    assign dIdx = {4'd0, addr};
    assign iIdx = 10'd512 + {2'd0, addr, 2'b00};

    always_comb begin
        data_out = 32'd0;
        if (MemRead) begin
            case (fun3)
                3'b000:  data_out = {{24{mem[dIdx][7]}}, mem[dIdx]};
                3'b001:  data_out = {{16{mem[dIdx + 10'd1][7]}}, mem[dIdx + 10'd1], mem[dIdx]};
                3'b010:  data_out = {mem[dIdx + 10'd3], mem[dIdx + 10'd2], mem[dIdx + 10'd1], mem[dIdx]};
                3'b100:  data_out = {24'd0, mem[dIdx]};
                3'b101:  data_out = {16'd0, mem[dIdx + 10'd1], mem[dIdx]};
                default: data_out = 32'd0;
            endcase
        end else begin
            data_out = {mem[iIdx + 10'd3], mem[iIdx + 10'd2], mem[iIdx + 10'd1], mem[iIdx]};
        end
    end

    always @(posedge clk) begin
        if (MemWrite) begin
            case (fun3)
                3'b000: mem[dIdx] <= data_in[7:0];
                3'b001: begin
                    mem[dIdx]         <= data_in[7:0];
                    mem[dIdx + 10'd1] <= data_in[15:8];
                end
                3'b010: begin
                    mem[dIdx]         <= data_in[7:0];
                    mem[dIdx + 10'd1] <= data_in[15:8];
                    mem[dIdx + 10'd2] <= data_in[23:16];
                    mem[dIdx + 10'd3] <= data_in[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyFetch(input logic [31:0] pc, input logic [31:0] expInstr);
        bit got;
        got    = 1'b0;
        if_req = 1'b1;
        if_pc  = pc;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (if_ready) got = 1'b1;
        end
        if (got) begin
            ifQ.push_back(expInstr);
        end else begin
            checks++;
            $display("[TB] FAIL fetch timeout pc=%h: if_ready stayed 0, expected 1", pc);
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic expErr, input logic [31:0] expData);
        bit got;
        got      = 1'b0;
        dm_req   = 1'b1;
        dm_we    = we;
        dm_fun3  = f3;
        dm_addr  = a;
        dm_wdata = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (dm_ready) got = 1'b1;
        end
        if (got) begin
            checkOutput("MemWrite", {32'd0, MemWrite}, {32'd0, !expErr && we});
            checkOutput("MemRead", {32'd0, MemRead}, {32'd0, !expErr && !we});
            if (if_req) begin
                checkOutput("if_stall", {32'd0, if_stall}, {32'd0, !expErr});
                if (expErr) ifQ.push_back(fetchExp);
            end
            dmQ.push_back({expErr, expData});
        end else begin
            checks++;
            $display("[TB] FAIL data timeout addr=%h: dm_ready stayed 0, expected 1", a);
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
    endtask

    // Monitor: every valid pulse must match the oldest expected response of its path.
    always @(negedge clk) begin
        if (rst) begin
            if (if_valid) begin
                if (ifQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL if_valid unexpected: got instr %h, expected no response", if_instr);
                end else begin
                    checkOutput("if_instr", {1'b0, if_instr}, {1'b0, ifQ.pop_front()});
                end
            end
            if (dm_valid) begin
                if (dmQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL dm_valid unexpected: got err/rdata %h, expected no response", {dm_err, dm_rdata});
                end else begin
                    checkOutput("dm_err/rdata", {dm_err, dm_rdata}, dmQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        passes   = 0;
        rst      = 1'b0;
        if_req   = 1'b0;
        if_pc    = 32'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_fun3  = 3'b000;
        dm_addr  = 32'd0;
        dm_wdata = 32'd0;
        fetchExp = 32'd0;
        for (int k = 0; k < 768; k++) mem[k] = 8'h00;
        for (int k = 0; k < 64; k++) begin
            mem[512 + 4*k]     = 8'(k);
            mem[512 + 4*k + 1] = 8'h00;
            mem[512 + 4*k + 2] = 8'hA5;
            mem[512 + 4*k + 3] = 8'hA5;
        end
        {mem[515], mem[514], mem[513], mem[512]} = 32'h00500093;
        {mem[519], mem[518], mem[517], mem[516]} = 32'h00A00113;
        {mem[523], mem[522], mem[521], mem[520]} = 32'h002081B3;
        mem[0] = 8'hF5;

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("reset if_valid", {32'd0, if_valid}, 33'd0);
        checkOutput("reset if_instr", {1'b0, if_instr}, 33'd0);
        checkOutput("reset dm_valid", {32'd0, dm_valid}, 33'd0);
        checkOutput("reset dm_rdata", {1'b0, dm_rdata}, 33'd0);
        checkOutput("reset dm_err", {32'd0, dm_err}, 33'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] fetch sequence");
        applyFetch(32'd0, 32'h00500093);
        applyFetch(32'd4, 32'h00A00113);
        applyFetch(32'd8, 32'h002081B3);

        $display("[TB] byte loads");
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 32'hFFFFFFF5);
        applyStimulus(1'b0, 3'b100, 32'd0, 32'd0, 1'b0, 32'h000000F5);

        $display("[TB] store then load with fetch waiting");
        if_req = 1'b1;
        if_pc  = 32'd12;
        applyStimulus(1'b1, 3'b010, 32'd8, 32'hDEADBEEF, 1'b0, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'd8, 32'd0, 1'b0, 32'hDEADBEEF);
        applyFetch(32'd12, 32'hA5A50003);

        $display("[TB] top-of-window accesses");
        applyStimulus(1'b1, 3'b010, 32'd60, 32'h0BADF00D, 1'b0, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'd60, 32'd0, 1'b0, 32'h0BADF00D);
        applyStimulus(1'b0, 3'b001, 32'd62, 32'd0, 1'b0, 32'h00000BAD);

        $display("[TB] illegal accesses");
        if_req   = 1'b1;
        if_pc    = 32'd16;
        fetchExp = 32'hA5A50004;
        applyStimulus(1'b0, 3'b010, 32'd6, 32'd0, 1'b1, 32'd0);
        applyStimulus(1'b0, 3'b001, 32'd3, 32'd0, 1'b1, 32'd0);
        applyStimulus(1'b1, 3'b010, 32'd62, 32'h12345678, 1'b1, 32'd0);
        applyStimulus(1'b0, 3'b100, 32'd64, 32'd0, 1'b1, 32'd0);
        applyStimulus(1'b1, 3'b100, 32'd0, 32'h00000077, 1'b1, 32'd0);
        if_req = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] starvation relief");
        if_req   = 1'b1;
        if_pc    = 32'd20;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_fun3  = 3'b010;
        dm_addr  = 32'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("starve dm_ready", {32'd0, dm_ready}, {32'd0, (i % 5) != 4});
            checkOutput("starve if_ready", {32'd0, if_ready}, {32'd0, (i % 5) == 4});
            if ((i % 5) == 4) ifQ.push_back(32'hA5A50005);
            else dmQ.push_back({1'b0, 32'hDEADBEEF});
            @(posedge clk);
            #1;
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset during a load grant");
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_fun3 = 3'b010;
        dm_addr = 32'd8;
        @(negedge clk);
        checkOutput("mid dm_ready", {32'd0, dm_ready}, 33'd1);
        checkOutput("mid MemRead", {32'd0, MemRead}, 33'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async if_instr", {1'b0, if_instr}, 33'd0);
        checkOutput("async dm_rdata", {1'b0, dm_rdata}, 33'd0);
        checkOutput("async if_valid", {32'd0, if_valid}, 33'd0);
        checkOutput("async dm_valid", {32'd0, dm_valid}, 33'd0);
        checkOutput("async dm_err", {32'd0, dm_err}, 33'd0);
        dm_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        applyFetch(32'd0, 32'h00500093);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ifQ drained", 33'(ifQ.size()), 33'd0);
        checkOutput("dmQ drained", 33'(dmQ.size()), 33'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
